// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the radix-2 DIF FFT control slice.
//   - LOG2N_DEF : default log2 of the FFT length
//   - IDLE..DONE: state encodings of the butterfly sequencer, plus the enum
//                 type built on them
//   - bitrev()  : reverses the low nbits of a value. Bins leave the in-place
//                 DIF in bit-reversed order, and the reader uses this to
//                 reorder them.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int LOG2N_DEF = 4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] READ   = 3'd1;
    localparam logic [2:0] LAUNCH = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_READ   = READ,
        ST_LAUNCH = LAUNCH,
        ST_WAIT   = WAIT,
        ST_WRITE  = WRITE,
        ST_DONE   = DONE
    } state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] x, input int nbits);
        logic [31:0] r;
        logic [31:0] y;
        r = '0;
        y = x;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r = {r[30:0], y[0]};
                y = y >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bf_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_bf_sequencer_if
//   The RAM-side and butterfly-side bus of the FFT butterfly sequencer.
//   master : the sequencer (drives RAM strobes/addresses, twiddle index,
//            bf_start; samples bf_valid)
//   slave  : the RAM / twiddle ROM / butterfly side
//   Signals:
//     mem_rd_en, mem_rd_addr_a, mem_rd_addr_b : RAM read port (A/B wings)
//     tw_addr                                 : twiddle ROM index
//     bf_start, bf_valid                      : butterfly start_calc/data_valid
//     mem_wr_en, mem_wr_addr_a, mem_wr_addr_b : RAM write-back (D->a, E->b)
// ---------------------------------------------------------------------------
interface fft_bf_sequencer_if
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
);
    logic             mem_rd_en;
    logic [LOG2N-1:0] mem_rd_addr_a;
    logic [LOG2N-1:0] mem_rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             bf_start;
    logic             bf_valid;
    logic             mem_wr_en;
    logic [LOG2N-1:0] mem_wr_addr_a;
    logic [LOG2N-1:0] mem_wr_addr_b;

    modport master (
        output mem_rd_en, mem_rd_addr_a, mem_rd_addr_b, tw_addr,
        output bf_start, mem_wr_en, mem_wr_addr_a, mem_wr_addr_b,
        input  bf_valid
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr_a, mem_rd_addr_b, tw_addr,
        input  bf_start, mem_wr_en, mem_wr_addr_a, mem_wr_addr_b,
        output bf_valid
    );
endinterface

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
//   Combinational address generator for one in-place radix-2 DIF butterfly.
//   Ports:
//     s  (in)  stage index 0..LOG2N-1
//     k  (in)  butterfly index 0..N/2-1 within the stage
//     a  (out) upper-wing sample address
//     b  (out) lower-wing sample address (a + span)
//     tw (out) twiddle ROM index
//   With span = N >> (s+1): pos = k mod span, grp = k / span,
//   a = grp*2*span + pos, tw = pos << s.
// ---------------------------------------------------------------------------
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic [LOG2N-1:0] s,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [LOG2N-2:0] tw
);
    localparam logic [LOG2N-1:0] HALF  = {1'b1, {(LOG2N-1){1'b0}}};
    localparam logic [LOG2N-2:0] KMASK = '1;
    localparam logic [LOG2N-1:0] S_MAX = LOG2N'(LOG2N - 1);

    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] s_inv;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-2:0] grp;

    always_comb begin
        span  = HALF >> s;
        s_inv = S_MAX - s;
        // span-1 is the low (LOG2N-1-s) bits of k
        pos   = k & (KMASK >> s);
        grp   = k >> s_inv;
        // grp << (LOG2N - s), split so no shift amount mixes widths
        a     = (({1'b0, grp} << s_inv) << 1) | {1'b0, pos};
        b     = a + span;
        tw    = pos << s;
    end
endmodule

// File: rtl/fft_bf_sequencer.sv
// ---------------------------------------------------------------------------
// fft_bf_sequencer
//   Control-side initiator of the butterfly start_calc/data_valid handshake.
//   Walks an in-place radix-2 DIF FFT over a 2^LOG2N sample RAM. Each
//   butterfly runs READ -> LAUNCH -> WAIT.. -> WRITE. After the last
//   butterfly of the last stage it spends one DONE cycle before IDLE.
//   Ports:
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     start      : 1-cycle run request, dropped unless IDLE
//     busy       : accepted start .. DONE cycle inclusive
//     done       : 1-cycle completion pulse (not raised on abort)
//     err        : sticky WAIT timeout flag, cleared by the next accepted start
//     stage      : current stage index (debug)
//     bus        : RAM / twiddle / butterfly bus (master side)
// ---------------------------------------------------------------------------
module fft_bf_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N    = LOG2N_DEF,
    parameter int WAIT_MAX = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LOG2N-1:0]   stage,
    fft_bf_sequencer_if.master bus
);
    localparam int               KW        = LOG2N - 1;
    localparam int               TMR_W     = $clog2(WAIT_MAX + 1);
    localparam logic [KW-1:0]    K_LAST    = '1;
    localparam logic [KW-1:0]    K_ONE     = KW'(1);
    localparam logic [LOG2N-1:0] S_LAST    = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] S_ONE     = LOG2N'(1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(WAIT_MAX - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    state_t           state_q, state_d;
    logic [LOG2N-1:0] s_q;
    logic [KW-1:0]    k_q;
    logic [TMR_W-1:0] timer_q;
    logic             err_q;

    logic [LOG2N-1:0] a_w, b_w;
    logic [KW-1:0]    tw_w;
    logic [LOG2N-1:0] a_p0, b_p0;
    logic [KW-1:0]    tw_p0;

    logic             accept;
    logic             timeout;
    logic             last_bf;

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .s  (s_q),
        .k  (k_q),
        .a  (a_w),
        .b  (b_w),
        .tw (tw_w)
    );

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        timeout           = 1'b0;
        last_bf           = (k_q == K_LAST) && (s_q == S_LAST);
        busy              = 1'b1;
        done              = 1'b0;
        bus.mem_rd_en     = 1'b0;
        bus.mem_rd_addr_a = '0;
        bus.mem_rd_addr_b = '0;
        bus.tw_addr       = '0;
        bus.bf_start      = 1'b0;
        bus.mem_wr_en     = 1'b0;
        bus.mem_wr_addr_a = '0;
        bus.mem_wr_addr_b = '0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                bus.mem_rd_en     = 1'b1;
                bus.mem_rd_addr_a = a_w;
                bus.mem_rd_addr_b = b_w;
                bus.tw_addr       = tw_w;
                state_d           = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                bus.tw_addr  = tw_p0;
                bus.bf_start = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                bus.tw_addr = tw_p0;
                // bf_valid wins over a timeout landing in the same cycle
                if (bus.bf_valid) begin
                    state_d = ST_WRITE;
                end else if (timer_q == TMR_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                bus.mem_wr_en     = 1'b1;
                bus.mem_wr_addr_a = a_p0;
                bus.mem_wr_addr_b = b_p0;
                state_d           = last_bf ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                s_q   <= '0;
                k_q   <= '0;
                err_q <= 1'b0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_LAUNCH) begin
                timer_q <= '0;
            end else if (state_q == ST_WAIT) begin
                timer_q <= timer_q + TMR_ONE;
            end
            if (state_q == ST_WRITE) begin
                if (k_q == K_LAST) begin
                    k_q <= '0;
                    // wrap after the final stage so stage stays in 0..LOG2N-1
                    s_q <= (s_q == S_LAST) ? '0 : s_q + S_ONE;
                end else begin
                    k_q <= k_q + K_ONE;
                end
            end
        end
    end

    // ---- stage p0: butterfly addresses captured at READ for write-back ----
    always_ff @(posedge clk) begin
        if (state_q == ST_READ) begin
            a_p0  <= a_w;
            b_p0  <= b_w;
            tw_p0 <= tw_w;
        end
    end

    assign err   = err_q;
    assign stage = s_q;

endmodule

// File: tb/tb_fft_bf_sequencer.sv
module tb_fft_bf_sequencer;
    localparam int LOG2N    = 4;
    localparam int N        = 16;
    localparam int NBF      = N / 2;
    localparam int TOTAL_BF = LOG2N * NBF;
    localparam int WAIT_MAX = 31;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic             err;
    logic [LOG2N-1:0] stage;

    fft_bf_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_bf_sequencer #(.LOG2N(LOG2N), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .stage (stage),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] tw;
        logic [7:0] s;
    } ev_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   n_start, n_wr, n_done, done_cyc, first_wr_cyc;
    int   due, lat_mode, cost_sum, cur_tw, tw_hold_bad;
    logic spur_en, start_on_done;
    ev_t  rd_q[$];
    ev_t  wr_q[$];
    ev_t  exp_q[$];

    function automatic ev_t mk(input int a, input int b, input int tw, input int s);
        ev_t e;
        e.a  = 8'(a);
        e.b  = 8'(b);
        e.tw = 8'(tw);
        e.s  = 8'(s);
        return e;
    endfunction

    // Reference butterfly order: stage by stage, group by group, position within group.
    function automatic void build_expected();
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            int span;
            span = N >> (s + 1);
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    exp_q.push_back(mk(g * 2 * span + p, g * 2 * span + p + span, p * (1 << s), s));
                end
            end
        end
    endfunction

    task automatic clear_run();
        rd_q.delete();
        wr_q.delete();
        n_start = 0; n_wr = 0; n_done = 0;
        done_cyc = -1; first_wr_cyc = -1;
        due = -1; cost_sum = 0; cur_tw = 0; tw_hold_bad = 0;
    endtask

    // One clock: observe the DUT in the current cycle, then drive this cycle's inputs.
    // The butterfly model answers lat_mode cycles after bf_start (0: random 1..8, -1: never).
    task automatic tick(input logic st);
        int   lat;
        logic in_wait;
        @(negedge clk);
        cyc++;
        in_wait = busy && !bus.mem_rd_en && !bus.bf_start && !bus.mem_wr_en && !done;
        if (bus.mem_rd_en) begin
            rd_q.push_back(mk(int'(bus.mem_rd_addr_a), int'(bus.mem_rd_addr_b),
                              int'(bus.tw_addr), int'(stage)));
            cur_tw = int'(bus.tw_addr);
        end
        if ((bus.bf_start || in_wait) && (int'(bus.tw_addr) != cur_tw)) tw_hold_bad++;
        if (bus.bf_start) begin
            n_start++;
            if (lat_mode >= 0) begin
                lat = (lat_mode > 0) ? lat_mode : int'($urandom_range(1, 8));
                due = cyc + lat;
                cost_sum += 3 + lat;
            end
        end
        if (bus.mem_wr_en) begin
            wr_q.push_back(mk(int'(bus.mem_wr_addr_a), int'(bus.mem_wr_addr_b), 0, int'(stage)));
            n_wr++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        bus.bf_valid = (cyc == due) ||
                       (spur_en && (bus.mem_rd_en || bus.bf_start || bus.mem_wr_en) &&
                        ($urandom_range(0, 1) == 1));
        start = st || (start_on_done && done);
    endtask

    task automatic kick();
        clear_run();
        cyc = -1;
        tick(1'b1);
    endtask

    task automatic apply_reset();
        start = 1'b0;
        bus.bf_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        bus.bf_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, stage} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b err=%b stage=%0d, want all 0", busy, done, err, stage);
        end
        checks++;
        if ({bus.mem_rd_en, bus.mem_rd_addr_a, bus.mem_rd_addr_b, bus.tw_addr, bus.bf_start} !== '0) begin
            errors++;
            $display("FAIL reset_rd: rd_en=%b a=%0d b=%0d tw=%0d bf_start=%b, want all 0",
                     bus.mem_rd_en, bus.mem_rd_addr_a, bus.mem_rd_addr_b, bus.tw_addr, bus.bf_start);
        end
        checks++;
        if ({bus.mem_wr_en, bus.mem_wr_addr_a, bus.mem_wr_addr_b} !== '0) begin
            errors++;
            $display("FAIL reset_wr: wr_en=%b a=%0d b=%0d, want all 0",
                     bus.mem_wr_en, bus.mem_wr_addr_a, bus.mem_wr_addr_b);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_sequences(input string tag);
        checks++;
        if (rd_q.size() != TOTAL_BF || wr_q.size() != TOTAL_BF) begin
            errors++;
            $display("FAIL %s_seq_len: rd=%0d wr=%0d, want %0d", tag, rd_q.size(), wr_q.size(), TOTAL_BF);
        end
        for (int i = 0; i < TOTAL_BF && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_rd[%0d]: got a=%0d b=%0d tw=%0d s=%0d, want a=%0d b=%0d tw=%0d s=%0d",
                         tag, i, rd_q[i].a, rd_q[i].b, rd_q[i].tw, rd_q[i].s,
                         exp_q[i].a, exp_q[i].b, exp_q[i].tw, exp_q[i].s);
            end
        end
        for (int i = 0; i < TOTAL_BF && i < wr_q.size(); i++) begin
            checks++;
            if ({wr_q[i].a, wr_q[i].b, wr_q[i].s} !== {exp_q[i].a, exp_q[i].b, exp_q[i].s}) begin
                errors++;
                $display("FAIL %s_wr[%0d]: got a=%0d b=%0d s=%0d, want a=%0d b=%0d s=%0d",
                         tag, i, wr_q[i].a, wr_q[i].b, wr_q[i].s, exp_q[i].a, exp_q[i].b, exp_q[i].s);
            end
        end
    endtask

    task automatic test_full_run();
        lat_mode = 4; spur_en = 1'b0; start_on_done = 1'b0;
        kick();
        for (int i = 0; i < 400 && n_done == 0; i++) tick(1'b0);
        repeat (3) tick(1'b0);
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL full_done_count: got %0d, want 1", n_done);
        end
        checks++;
        if (done_cyc != TOTAL_BF * 7 + 1) begin
            errors++;
            $display("FAIL full_done_cycle: got %0d, want %0d", done_cyc, TOTAL_BF * 7 + 1);
        end
        checks++;
        if (n_start != TOTAL_BF || n_wr != TOTAL_BF) begin
            errors++;
            $display("FAIL full_pulses: bf_start=%0d wr_en=%0d, want %0d each", n_start, n_wr, TOTAL_BF);
        end
        checks++;
        if (first_wr_cyc != 7) begin
            errors++;
            $display("FAIL full_first_wr_cycle: got %0d, want 7", first_wr_cyc);
        end
        checks++;
        if (rd_q[0] !== mk(0, 8, 0, 0) || rd_q[3] !== mk(3, 11, 3, 0)) begin
            errors++;
            $display("FAIL anchor_s0: k0 a=%0d b=%0d tw=%0d, k3 a=%0d b=%0d tw=%0d, want 0/8/0 and 3/11/3",
                     rd_q[0].a, rd_q[0].b, rd_q[0].tw, rd_q[3].a, rd_q[3].b, rd_q[3].tw);
        end
        checks++;
        if (rd_q[12] !== mk(8, 12, 0, 1) || rd_q[13] !== mk(9, 13, 2, 1) || rd_q[31] !== mk(14, 15, 0, 3)) begin
            errors++;
            $display("FAIL anchor_s1_s3: s1k4 %0d/%0d/%0d s1k5 %0d/%0d/%0d s3k7 %0d/%0d/%0d, want 8/12/0 9/13/2 14/15/0",
                     rd_q[12].a, rd_q[12].b, rd_q[12].tw, rd_q[13].a, rd_q[13].b, rd_q[13].tw,
                     rd_q[31].a, rd_q[31].b, rd_q[31].tw);
        end
        check_sequences("full");
        checks++;
        if (tw_hold_bad != 0) begin
            errors++;
            $display("FAIL full_tw_hold: %0d cycles with tw_addr changed in LAUNCH/WAIT, want 0", tw_hold_bad);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL full_end_state: busy=%b err=%b, want 0 0", busy, err);
        end
    endtask

    task automatic test_back_to_back_random();
        lat_mode = 0; spur_en = 1'b1; start_on_done = 1'b1;
        kick();
        for (int i = 0; i < 600 && n_done == 0; i++) tick($urandom_range(0, 15) == 0);
        start_on_done = 1'b0;
        repeat (5) tick(1'b0);
        checks++;
        if (n_done != 1 || done_cyc != cost_sum + 1) begin
            errors++;
            $display("FAIL rand_done: count=%0d cycle=%0d, want 1 at %0d", n_done, done_cyc, cost_sum + 1);
        end
        checks++;
        if (n_start != TOTAL_BF || n_wr != TOTAL_BF) begin
            errors++;
            $display("FAIL rand_pulses: bf_start=%0d wr_en=%0d, want %0d each", n_start, n_wr, TOTAL_BF);
        end
        check_sequences("rand");
        checks++;
        if (tw_hold_bad != 0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rand_end: tw_hold_bad=%0d busy=%b err=%b, want 0 0 0", tw_hold_bad, busy, err);
        end
    endtask

    task automatic test_timeout();
        logic b33, b34, e34, e1;
        b33 = 1'b0; b34 = 1'b1; e34 = 1'b0; e1 = 1'b1;
        lat_mode = -1; spur_en = 1'b0; start_on_done = 1'b0;
        kick();
        for (int i = 0; i < 45; i++) begin
            tick(1'b0);
            if (cyc == 33) b33 = busy;
            if (cyc == 34) begin
                b34 = busy;
                e34 = err;
            end
        end
        checks++;
        if (b33 !== 1'b1 || b34 !== 1'b0 || e34 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge: busy@33=%b busy@34=%b err@34=%b, want 1 0 1", b33, b34, e34);
        end
        checks++;
        if (n_done != 0 || n_wr != 0 || n_start != 1) begin
            errors++;
            $display("FAIL timeout_pulses: done=%0d wr=%0d bf_start=%0d, want 0 0 1", n_done, n_wr, n_start);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b, want 1", err);
        end
        // bf_valid on the very last WAIT cycle must count as valid
        lat_mode = WAIT_MAX;
        kick();
        tick(1'b0);
        e1 = err;
        for (int i = 0; i < 40 && n_wr == 0; i++) tick(1'b0);
        checks++;
        if (e1 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: err=%b after new start, want 0", e1);
        end
        checks++;
        if (first_wr_cyc != 3 + WAIT_MAX || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_tie_valid: wr at %0d err=%b, want wr at %0d err=0",
                     first_wr_cyc, err, 3 + WAIT_MAX);
        end
    endtask

    task automatic test_reset_mid_run();
        int   wr_before;
        logic found;
        found = 1'b0;
        apply_reset();
        lat_mode = 4; spur_en = 1'b0; start_on_done = 1'b0;
        kick();
        for (int i = 0; i < 400 && !found; i++) begin
            tick(1'b0);
            if (stage == 2 && busy && !bus.mem_rd_en && !bus.bf_start && !bus.mem_wr_en && !done)
                found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_find_wait: no WAIT cycle in stage 2 within bound, want one");
        end
        wr_before = n_wr;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, stage, bus.mem_rd_en, bus.mem_rd_addr_a, bus.mem_rd_addr_b,
             bus.tw_addr, bus.bf_start, bus.mem_wr_en, bus.mem_wr_addr_a, bus.mem_wr_addr_b} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b done=%b err=%b stage=%0d rd_en=%b bf_start=%b wr_en=%b, want all 0",
                     busy, done, err, stage, bus.mem_rd_en, bus.bf_start, bus.mem_wr_en);
        end
        repeat (2) tick(1'b0);
        rst_n = 1'b1;
        checks++;
        if (n_wr != wr_before) begin
            errors++;
            $display("FAIL midrst_no_write: wr count %0d, want %0d", n_wr, wr_before);
        end
        kick();
        tick(1'b0);
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== mk(0, 8, 0, 0)) begin
            errors++;
            $display("FAIL midrst_restart: reads=%0d first a=%0d b=%0d tw=%0d s=%0d, want 1 read 0/8/0/0",
                     rd_q.size(), rd_q[0].a, rd_q[0].b, rd_q[0].tw, rd_q[0].s);
        end
        apply_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bf_valid  = 1'b0;
        lat_mode      = 4;
        spur_en       = 1'b0;
        start_on_done = 1'b0;
        cyc           = 0;
        clear_run();
        build_expected();
        test_reset();
        test_full_run();
        test_back_to_back_random();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
